guvm_core_responder: RTL and testbench
======================================

Name: guvm_core_responder

Overview:
- Synthesisable responder that stands in for the instruction and data caches in front of an integer-unit core under GUVM test.
- The bench pushes instruction words and load-data words into per-channel FIFOs.
- The block answers core fetch and load requests with a programmable number of wait states, driving the core's hold inputs.
- Store data from the core is captured into a readback FIFO for the monitor. This generalises the fixed single-word send_inst/send_data path to queued, wait-stated, parametrised traffic.

Parameters:
- DATA_W, 32, width of instruction, load and store words
- INST_DEPTH, 16, instruction FIFO entries (>=2, any integer)
- DATA_DEPTH, 8, load-data FIFO entries (>=2)
- CAP_DEPTH, 8, store-capture FIFO entries (>=2)
- WAIT_W, 4, width of the wait-state count

Ports:
- clk  in  1  core clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- inst_wr_en  in  1  bench pushes inst_wr_data
- inst_wr_data  in  DATA_W  instruction word
- inst_full  out  1  instruction FIFO full
- data_wr_en  in  1  bench pushes data_wr_data
- data_wr_data  in  DATA_W  load-response word
- data_full  out  1  load FIFO full
- wait_cycles  in  WAIT_W  wait states per response, sampled at request accept
- fetch_req  in  1  core instruction request
- inst_out  out  DATA_W  instruction to core (icache data)
- inst_hold  out  1  icache hold; 1 = no stall, 0 = stall core
- load_req  in  1  core load request
- store_req  in  1  core store strobe
- store_data  in  DATA_W  core store word (dcache edata)
- data_out  out  DATA_W  load word to core (dcache data)
- data_hold  out  1  dcache hold; 1 = no stall, 0 = stall
- cap_rd_en  in  1  monitor pops capture FIFO
- cap_rd_data  out  DATA_W  head of capture FIFO (registered, updates on pop)
- cap_empty  out  1  capture FIFO empty
- overflow  out  1  sticky: push to any full FIFO
- starve  out  1  sticky: a wait expired with the channel FIFO empty

Behaviour:
- Reset (async, immediate):
  - All FIFOs empty, both FSMs go to IDLE, counters 0.
  - Outputs: inst_out = 0, data_out = 0, inst_hold = 1, data_hold = 1, inst_full = 0, data_full = 0, cap_empty = 1, cap_rd_data = 0, overflow = 0, starve = 0.
  - Reset mid-wait discards the pending request; the popped word is not restored.
- FIFOs:
  - Circular, pointers wrap at DEPTH-1 -> 0, separate occupancy counter.
  - full = (count == DEPTH).
  - Push and pop in the same cycle: both occur, count unchanged, legal even when full.
  - Push while full without a pop: push dropped, overflow set.
  - Pop while empty: never issued internally; cap_rd_en while empty is ignored.
- Channel FSM (identical for the fetch and load channels), states IDLE, WAIT, RESP:
  - IDLE: hold = 1; out holds its last value.
    - req=1 and wait_cycles=0 and FIFO non-empty -> RESP.
    - Otherwise, on req=1: cnt <= wait_cycles, go to WAIT.
  - WAIT: hold = 0.
    - cnt > 0: decrement.
    - cnt == 0 and FIFO non-empty -> RESP.
    - cnt == 0 and FIFO empty: stay in WAIT, set starve (first such cycle), keep stalling until a word is pushed.
  - RESP: pop the head into out (registered); hold = 1 for exactly this cycle.
    - req=1 in RESP is accepted as in IDLE (back-to-back).
    - Otherwise return to IDLE.
  - Requests in WAIT are ignored (core is stalled).
- Latency and throughput:
  - Request at cycle N with 0 waits and data available -> out valid at N+1, hold never drops; sustained one word per cycle.
  - With W waits: hold = 0 for cycles N+1 .. N+W+1, word valid at N+W+2.
- Stores:
  - store_req=1 pushes store_data into the capture FIFO in the same cycle, regardless of load FSM state.
  - Simultaneous store_req and load_req are both serviced.
  - Store to a full capture FIFO: dropped, overflow set.
- Flags: overflow and starve are cleared only by rst.

Test Plan:
- Reset, then push 0x8E00C002, 0x01000000 to the inst FIFO, wait_cycles=0, hold fetch_req=1 for 2 cycles -> inst_out = 0x8E00C002 then 0x01000000 on consecutive cycles, inst_hold constantly 1.
- wait_cycles=3, one data word 0x00000013, pulse load_req at cycle N -> data_hold = 0 for cycles N+1..N+4, data_out = 0x13 with data_hold = 1 at N+5.
- fetch_req with an empty inst FIFO, wait_cycles=0 -> inst_hold = 0 and starve = 1; push 0xA0102001 five cycles later -> word delivered the cycle after the FSM sees the non-empty FIFO, inst_hold returns to 1.
- Push 9 words into a DATA_DEPTH=8 FIFO -> data_full = 1 after 8 pushes, overflow = 1, 9th word is never returned.
- store_req with 0xDEADBEEF and 0x12345678 alongside an active load -> cap_empty drops, two cap_rd_en pops return both in order, cap_empty = 1 afterwards.
- Assert rst during WAIT with cnt=2 -> all holds 1, outputs 0, FIFOs empty, flags 0 immediately without a clock edge; a subsequent request behaves as after a fresh reset.

Source files
------------

// File: rtl/guvm_core_responder.sv
// Cache stand-in for a core under test: queued instruction/load responses with
// programmable wait states, plus a capture FIFO for core store data.
module guvm_core_responder #(
    parameter int DATA_W     = 32,
    parameter int INST_DEPTH = 16,
    parameter int DATA_DEPTH = 8,
    parameter int CAP_DEPTH  = 8,
    parameter int WAIT_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_wr_en,
    input  logic [DATA_W-1:0] inst_wr_data,
    output logic              inst_full,
    input  logic              data_wr_en,
    input  logic [DATA_W-1:0] data_wr_data,
    output logic              data_full,
    input  logic [WAIT_W-1:0] wait_cycles,
    input  logic              fetch_req,
    output logic [DATA_W-1:0] inst_out,
    output logic              inst_hold,
    input  logic              load_req,
    input  logic              store_req,
    input  logic [DATA_W-1:0] store_data,
    output logic [DATA_W-1:0] data_out,
    output logic              data_hold,
    input  logic              cap_rd_en,
    output logic [DATA_W-1:0] cap_rd_data,
    output logic              cap_empty,
    output logic              overflow,
    output logic              starve
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // FIFO index: 0 = instruction, 1 = load data, 2 = store capture
    logic [2:0]             f_push, f_pop, f_empty, f_full;
    logic [2:0][DATA_W-1:0] f_wdata, f_head;

    // Channel index: 0 = fetch, 1 = load
    logic [1:0]             ch_req, ch_pop, ch_hold, ch_starve;
    logic [1:0][DATA_W-1:0] ch_out;

    logic              overflow_q, overflow_d;
    logic              starve_q, starve_d;
    logic [DATA_W-1:0] cap_q, cap_d;

    assign f_push  = {store_req, data_wr_en, inst_wr_en};
    assign f_wdata = {store_data, data_wr_data, inst_wr_data};
    // Channel pops are only raised with a non-empty FIFO; monitor pops are gated here.
    assign f_pop   = {cap_rd_en & ~f_empty[2], ch_pop};
    assign ch_req  = {load_req, fetch_req};

    for (genvar g = 0; g < 3; g++) begin : g_fifo
        localparam int D  = (g == 0) ? INST_DEPTH : (g == 1) ? DATA_DEPTH : CAP_DEPTH;
        localparam int AW = $clog2(D);
        localparam int CW = $clog2(D + 1);
        localparam logic [AW-1:0] LAST  = AW'(D - 1);
        localparam logic [CW-1:0] FULLV = CW'(D);

        logic [DATA_W-1:0] mem_q [D];
        logic [AW-1:0]     wptr_q, rptr_q;
        logic [CW-1:0]     cnt_q;
        logic              do_push;

        // A pop frees a slot in the same cycle, so push+pop is legal when full.
        assign do_push    = f_push[g] && (!f_full[g] || f_pop[g]);
        assign f_full[g]  = (cnt_q == FULLV);
        assign f_empty[g] = (cnt_q == '0);
        assign f_head[g]  = mem_q[rptr_q];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
            end else begin
                if (do_push)
                    wptr_q <= (wptr_q == LAST) ? '0 : wptr_q + AW'(1);
                if (f_pop[g])
                    rptr_q <= (rptr_q == LAST) ? '0 : rptr_q + AW'(1);
                if (do_push && !f_pop[g])
                    cnt_q <= cnt_q + CW'(1);
                else if (!do_push && f_pop[g])
                    cnt_q <= cnt_q - CW'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (do_push)
                mem_q[wptr_q] <= f_wdata[g];
        end
    end

    for (genvar c = 0; c < 2; c++) begin : g_chan
        logic [1:0]        st_q, st_d;
        logic [WAIT_W-1:0] cnt_q, cnt_d;
        logic [DATA_W-1:0] out_q, out_d;
        logic              go;

        // The word is loaded on entry to RESP so it is valid during the RESP cycle.
        always_comb begin
            st_d  = st_q;
            cnt_d = cnt_q;
            go    = 1'b0;
            case (st_q)
                S_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - WAIT_W'(1);
                    end else if (!f_empty[c]) begin
                        go   = 1'b1;
                        st_d = S_RESP;
                    end
                end
                default: begin
                    if (ch_req[c]) begin
                        if (wait_cycles == '0 && !f_empty[c]) begin
                            go   = 1'b1;
                            st_d = S_RESP;
                        end else begin
                            st_d  = S_WAIT;
                            cnt_d = wait_cycles;
                        end
                    end else begin
                        st_d = S_IDLE;
                    end
                end
            endcase
            out_d = go ? f_head[c] : out_q;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                st_q  <= S_IDLE;
                cnt_q <= '0;
                out_q <= '0;
            end else begin
                st_q  <= st_d;
                cnt_q <= cnt_d;
                out_q <= out_d;
            end
        end

        assign ch_pop[c]    = go;
        assign ch_hold[c]   = (st_q != S_WAIT);
        assign ch_out[c]    = out_q;
        assign ch_starve[c] = (st_q == S_WAIT) && (cnt_q == '0) && f_empty[c];
    end

    always_comb begin
        overflow_d = overflow_q | (|(f_push & f_full & ~f_pop));
        starve_d   = starve_q | (|ch_starve);
        cap_d      = f_pop[2] ? f_head[2] : cap_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
            starve_q   <= 1'b0;
            cap_q      <= '0;
        end else begin
            overflow_q <= overflow_d;
            starve_q   <= starve_d;
            cap_q      <= cap_d;
        end
    end

    assign inst_full   = f_full[0];
    assign data_full   = f_full[1];
    assign cap_empty   = f_empty[2];
    assign inst_out    = ch_out[0];
    assign inst_hold   = ch_hold[0];
    assign data_out    = ch_out[1];
    assign data_hold   = ch_hold[1];
    assign cap_rd_data = cap_q;
    assign overflow    = overflow_q;
    assign starve      = starve_q;

endmodule

// File: tb/tb_guvm_core_responder.sv
// Directed bench for guvm_core_responder: fetch/load latency, starvation,
// overflow, store capture and asynchronous reset.
module tb_guvm_core_responder;

    logic        clk;
    logic        rst;
    logic        inst_wr_en;
    logic [31:0] inst_wr_data;
    logic        inst_full;
    logic        data_wr_en;
    logic [31:0] data_wr_data;
    logic        data_full;
    logic [3:0]  wait_cycles;
    logic        fetch_req;
    logic [31:0] inst_out;
    logic        inst_hold;
    logic        load_req;
    logic        store_req;
    logic [31:0] store_data;
    logic [31:0] data_out;
    logic        data_hold;
    logic        cap_rd_en;
    logic [31:0] cap_rd_data;
    logic        cap_empty;
    logic        overflow;
    logic        starve;

    int errors = 0;
    int checks = 0;

    guvm_core_responder dut (
        .clk          (clk),
        .rst          (rst),
        .inst_wr_en   (inst_wr_en),
        .inst_wr_data (inst_wr_data),
        .inst_full    (inst_full),
        .data_wr_en   (data_wr_en),
        .data_wr_data (data_wr_data),
        .data_full    (data_full),
        .wait_cycles  (wait_cycles),
        .fetch_req    (fetch_req),
        .inst_out     (inst_out),
        .inst_hold    (inst_hold),
        .load_req     (load_req),
        .store_req    (store_req),
        .store_data   (store_data),
        .data_out     (data_out),
        .data_hold    (data_hold),
        .cap_rd_en    (cap_rd_en),
        .cap_rd_data  (cap_rd_data),
        .cap_empty    (cap_empty),
        .overflow     (overflow),
        .starve       (starve)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " inst_out"},    inst_out, 32'h0);
        chk({tag, " data_out"},    data_out, 32'h0);
        chk({tag, " inst_hold"},   {31'h0, inst_hold}, 32'h1);
        chk({tag, " data_hold"},   {31'h0, data_hold}, 32'h1);
        chk({tag, " inst_full"},   {31'h0, inst_full}, 32'h0);
        chk({tag, " data_full"},   {31'h0, data_full}, 32'h0);
        chk({tag, " cap_empty"},   {31'h0, cap_empty}, 32'h1);
        chk({tag, " cap_rd_data"}, cap_rd_data, 32'h0);
        chk({tag, " overflow"},    {31'h0, overflow}, 32'h0);
        chk({tag, " starve"},      {31'h0, starve}, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        inst_wr_en = 0; inst_wr_data = 0; data_wr_en = 0; data_wr_data = 0;
        wait_cycles = 0; fetch_req = 0; load_req = 0; store_req = 0;
        store_data = 0; cap_rd_en = 0;
        step();
        step();
        chk_reset_state("reset");
        rst = 1'b0;
        step();

        // Zero-wait back-to-back fetch
        inst_wr_en = 1; inst_wr_data = 32'h8E00C002; step();
        inst_wr_data = 32'h01000000; step();
        inst_wr_en = 0;
        wait_cycles = 0; fetch_req = 1;
        chk("fetch0 hold N", {31'h0, inst_hold}, 32'h1);
        step();
        chk("fetch0 word0", inst_out, 32'h8E00C002);
        chk("fetch0 hold N+1", {31'h0, inst_hold}, 32'h1);
        step();
        chk("fetch0 word1", inst_out, 32'h01000000);
        chk("fetch0 hold N+2", {31'h0, inst_hold}, 32'h1);
        fetch_req = 0;
        step();
        chk("fetch0 idle keeps word", inst_out, 32'h01000000);
        chk("fetch0 idle hold", {31'h0, inst_hold}, 32'h1);

        // Load with three wait states
        data_wr_en = 1; data_wr_data = 32'h00000013; step();
        data_wr_en = 0;
        wait_cycles = 3; load_req = 1;
        chk("load3 hold N", {31'h0, data_hold}, 32'h1);
        step();
        load_req = 0;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("load3 stall N+%0d", i), {31'h0, data_hold}, 32'h0);
            step();
        end
        chk("load3 hold N+5", {31'h0, data_hold}, 32'h1);
        chk("load3 word N+5", data_out, 32'h00000013);
        step();
        chk("load3 idle hold", {31'h0, data_hold}, 32'h1);

        // Fetch from an empty FIFO starves until a word arrives
        wait_cycles = 0; fetch_req = 1;
        step();
        fetch_req = 0;
        chk("starve stall", {31'h0, inst_hold}, 32'h0);
        step();
        chk("starve flag", {31'h0, starve}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("starve still stalled %0d", i), {31'h0, inst_hold}, 32'h0);
            step();
        end
        inst_wr_en = 1; inst_wr_data = 32'hA0102001; step();
        inst_wr_en = 0;
        chk("starve push edge hold", {31'h0, inst_hold}, 32'h0);
        step();
        chk("starve resp hold", {31'h0, inst_hold}, 32'h1);
        chk("starve resp word", inst_out, 32'hA0102001);
        step();

        // Overflow of the load FIFO
        chk("ovf clear before", {31'h0, overflow}, 32'h0);
        data_wr_en = 1;
        for (int i = 0; i < 8; i++) begin
            data_wr_data = 32'h100 + 32'(i);
            step();
        end
        chk("ovf full after 8", {31'h0, data_full}, 32'h1);
        chk("ovf not yet", {31'h0, overflow}, 32'h0);
        data_wr_data = 32'h108; step();
        data_wr_en = 0;
        chk("ovf set", {31'h0, overflow}, 32'h1);
        chk("ovf still full", {31'h0, data_full}, 32'h1);
        wait_cycles = 0; load_req = 1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("ovf drain %0d", i), data_out, 32'h100 + 32'(i));
        end
        load_req = 0;
        step();
        chk("ovf 9th dropped", data_out, 32'h107);
        chk("ovf not full", {31'h0, data_full}, 32'h0);

        // Stores alongside a waited load
        data_wr_en = 1; data_wr_data = 32'h00000055; step();
        data_wr_en = 0;
        wait_cycles = 2; load_req = 1; store_req = 1; store_data = 32'hDEADBEEF;
        step();
        load_req = 0; store_data = 32'h12345678;
        step();
        store_req = 0;
        chk("cap not empty", {31'h0, cap_empty}, 32'h0);
        chk("store load stalled", {31'h0, data_hold}, 32'h0);
        cap_rd_en = 1;
        step();
        chk("cap pop0", cap_rd_data, 32'hDEADBEEF);
        step();
        chk("cap pop1", cap_rd_data, 32'h12345678);
        cap_rd_en = 0;
        chk("cap empty after", {31'h0, cap_empty}, 32'h1);
        chk("store load word", data_out, 32'h00000055);
        chk("store load hold", {31'h0, data_hold}, 32'h1);
        cap_rd_en = 1;
        step();
        cap_rd_en = 0;
        chk("cap pop empty ignored", cap_rd_data, 32'h12345678);

        // Asynchronous reset in the middle of a wait
        inst_wr_en = 1; inst_wr_data = 32'h11111111; step();
        inst_wr_en = 0;
        wait_cycles = 3; fetch_req = 1; store_req = 1; store_data = 32'h00000077;
        step();
        fetch_req = 0; store_req = 0;
        step();
        chk("pre-rst stalled", {31'h0, inst_hold}, 32'h0);
        chk("pre-rst cap filled", {31'h0, cap_empty}, 32'h0);
        rst = 1'b1;
        #1;
        chk_reset_state("async rst");
        step();
        rst = 1'b0;
        inst_wr_en = 1; inst_wr_data = 32'h22222222; step();
        inst_wr_en = 0;
        wait_cycles = 0; fetch_req = 1;
        step();
        fetch_req = 0;
        chk("post-rst word", inst_out, 32'h22222222);
        chk("post-rst hold", {31'h0, inst_hold}, 32'h1);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
